// File: rtl/synth_pkg.sv
// Common types and rules for the synth slot sequencer.
// Holds the FSM state encoding and the voice-count clamp.
package synth_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Zero or out-of-range requests fall back to a full frame.
    function automatic int clamp_voices(input int av, input int voices);
        if (av == 0 || av > voices) begin
            return voices;
        end
        return av;
    endfunction

endpackage

// File: rtl/utils.sv
// Shared elaboration-time helpers.
// Used for sizing counter and index fields.
package utils;

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/synth_slot_cnt.sv
// Cascaded cycle/env/voice slot counter.
// Exposes next-state values so the parent can register its decodes.
module synth_slot_cnt #(
    parameter int V_ENVS      = 16,
    parameter int SLOT_CYCLES = 4,
    parameter int V_WIDTH     = 5,
    parameter int E_WIDTH     = 4,
    parameter int CY_WIDTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic [V_WIDTH-1:0]  last_voice,
    output logic [CY_WIDTH-1:0] cyc_d,
    output logic [E_WIDTH-1:0]  env_d,
    output logic [V_WIDTH-1:0]  voice_d,
    output logic [E_WIDTH-1:0]  env_q,
    output logic [V_WIDTH-1:0]  voice_q,
    output logic                tc
);

    localparam logic [CY_WIDTH-1:0] CYC_LAST = CY_WIDTH'(SLOT_CYCLES - 1);
    localparam logic [E_WIDTH-1:0]  ENV_LAST = E_WIDTH'(V_ENVS - 1);

    logic [CY_WIDTH-1:0] cyc_q;
    logic                cyc_wrap;
    logic                env_wrap;

    assign cyc_wrap = (cyc_q == CYC_LAST);
    assign env_wrap = (env_q == ENV_LAST);
    assign tc       = en && cyc_wrap && env_wrap && (voice_q == last_voice);

    always_comb begin
        cyc_d   = cyc_q;
        env_d   = env_q;
        voice_d = voice_q;
        if (clr) begin
            cyc_d   = '0;
            env_d   = '0;
            voice_d = '0;
        end else if (en) begin
            if (cyc_wrap) begin
                cyc_d = '0;
                if (env_wrap) begin
                    env_d   = '0;
                    voice_d = voice_q + 1'b1;
                end else begin
                    env_d = env_q + 1'b1;
                end
            end else begin
                cyc_d = cyc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q   <= '0;
            env_q   <= '0;
            voice_q <= '0;
        end else begin
            cyc_q   <= cyc_d;
            env_q   <= env_d;
            voice_q <= voice_d;
        end
    end

endmodule

// File: rtl/synth_slot_seq.sv
// Frame sequencer: walks voice/envelope slots once per trigger.
// All outputs are registered from next-state decodes.
module synth_slot_seq
    import synth_pkg::*;
#(
    parameter int VOICES      = 32,
    parameter int V_OSC       = 8,
    parameter int O_ENVS      = 2,
    parameter int SLOT_CYCLES = 4,
    parameter int CHANNELS    = 4,
    localparam int V_ENVS     = V_OSC * O_ENVS,
    localparam int V_WIDTH    = utils::clogb2(VOICES),
    localparam int O_WIDTH    = utils::clogb2(V_OSC),
    localparam int OE_WIDTH   = utils::clogb2(O_ENVS),
    localparam int E_WIDTH    = O_WIDTH + OE_WIDTH,
    localparam int C_WIDTH    = utils::clogb2(CHANNELS)
) (
    input  logic                       AUDIO_CLK,
    input  logic                       reset_reg,
    input  logic                       trig,
    input  logic [V_WIDTH:0]           active_voices,
    input  logic                       ovr_clr,
    output logic                       sCLK_XVXENVS,
    output logic                       sCLK_XVXOSC,
    output logic [V_WIDTH+E_WIDTH-1:0] xxxx,
    output logic [C_WIDTH-1:0]         channel,
    output logic                       xxxx_zero,
    output logic                       run,
    output logic                       frame_done,
    output logic                       overrun
);

    localparam int CY_WIDTH = utils::clogb2(SLOT_CYCLES);
    localparam int VPC      = VOICES / CHANNELS;

    state_e state_q, state_d;
    logic [V_WIDTH:0]   n_q, n_d;
    logic               run_q, run_d;
    logic               envs_q, envs_d;
    logic               osc_q, osc_d;
    logic               zero_q, zero_d;
    logic               done_q, done_d;
    logic               ovr_q, ovr_d;
    logic [C_WIDTH-1:0] chan_q, chan_d;

    logic                cnt_clr;
    logic                cnt_en;
    logic                tc;
    logic [CY_WIDTH-1:0] cyc_d;
    logic [E_WIDTH-1:0]  env_d, env_q;
    logic [V_WIDTH-1:0]  voice_d, voice_q;
    logic [V_WIDTH-1:0]  last_voice;

    assign last_voice = V_WIDTH'(n_q - 1'b1);
    assign cnt_en     = (state_q == ST_RUN);
    assign cnt_clr    = (state_q != ST_RUN) || tc;

    synth_slot_cnt #(
        .V_ENVS      (V_ENVS),
        .SLOT_CYCLES (SLOT_CYCLES),
        .V_WIDTH     (V_WIDTH),
        .E_WIDTH     (E_WIDTH),
        .CY_WIDTH    (CY_WIDTH)
    ) u_cnt (
        .clk        (AUDIO_CLK),
        .rst        (reset_reg),
        .clr        (cnt_clr),
        .en         (cnt_en),
        .last_voice (last_voice),
        .cyc_d      (cyc_d),
        .env_d      (env_d),
        .voice_d    (voice_d),
        .env_q      (env_q),
        .voice_q    (voice_q),
        .tc         (tc)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        unique case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d = ST_RUN;
                    n_d     = (V_WIDTH+1)'(clamp_voices(int'(active_voices), VOICES));
                end
            end
            ST_RUN: begin
                if (tc) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Strobes are decoded from next-state so they line up with xxxx.
    always_comb begin
        run_d  = (state_d == ST_RUN);
        envs_d = run_d && (cyc_d == '0);
        osc_d  = envs_d && (env_d[OE_WIDTH-1:0] == '0);
        zero_d = envs_d && (env_d == '0) && (voice_d == '0);
        done_d = (state_q == ST_RUN) && tc;
        chan_d = run_d ? C_WIDTH'(int'(voice_d) / VPC) : '0;
        ovr_d  = ovr_q;
        if (state_q == ST_RUN && trig) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge AUDIO_CLK) begin
        if (reset_reg) begin
            state_q <= ST_IDLE;
            n_q     <= (V_WIDTH+1)'(VOICES);
            run_q   <= 1'b0;
            envs_q  <= 1'b0;
            osc_q   <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            run_q   <= run_d;
            envs_q  <= envs_d;
            osc_q   <= osc_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            chan_q  <= chan_d;
        end
    end

    assign sCLK_XVXENVS = envs_q;
    assign sCLK_XVXOSC  = osc_q;
    assign xxxx         = {voice_q, env_q};
    assign channel      = chan_q;
    assign xxxx_zero    = zero_q;
    assign run          = run_q;
    assign frame_done   = done_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_synth_slot_seq.sv
// Directed bench for synth_slot_seq with default parameters.
// Table of frame sizes plus hand sequences for overrun and reset.
module tb_synth_slot_seq;

    logic       AUDIO_CLK = 1'b0;
    logic       reset_reg;
    logic       trig;
    logic [5:0] active_voices;
    logic       ovr_clr;
    logic       sCLK_XVXENVS;
    logic       sCLK_XVXOSC;
    logic [8:0] xxxx;
    logic [1:0] channel;
    logic       xxxx_zero;
    logic       run;
    logic       frame_done;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int av;
        int len;
        int envs;
        int osc;
    } vec_t;

    typedef struct {
        int len;
        int envs;
        int osc;
        int zero;
        int done_at;
        int first_ok;
        int seq_ok;
        int ch_ok;
        int ch9;
        int ch31;
    } res_t;

    synth_slot_seq dut (
        .AUDIO_CLK     (AUDIO_CLK),
        .reset_reg     (reset_reg),
        .trig          (trig),
        .active_voices (active_voices),
        .ovr_clr       (ovr_clr),
        .sCLK_XVXENVS  (sCLK_XVXENVS),
        .sCLK_XVXOSC   (sCLK_XVXOSC),
        .xxxx          (xxxx),
        .channel       (channel),
        .xxxx_zero     (xxxx_zero),
        .run           (run),
        .frame_done    (frame_done),
        .overrun       (overrun)
    );

    always #5 AUDIO_CLK = ~AUDIO_CLK;

    task automatic step();
        @(posedge AUDIO_CLK);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Trigger a frame and observe it until frame_done, abort, or budget.
    task automatic frame(input int av, input int trig_at, input int clr_at,
                         input int rst_at, output res_t r);
        int k;
        r = '{default: 0};
        r.seq_ok = 1;
        r.ch_ok  = 1;
        r.ch9    = -1;
        r.ch31   = -1;
        k = 0;
        active_voices = 6'(av);
        trig = 1'b1;
        step();
        trig = 1'b0;
        active_voices = 6'd7;
        for (int i = 1; i <= 4000; i++) begin
            if (frame_done) begin
                r.done_at = i;
                break;
            end
            if (!run) begin
                break;
            end
            if (i == 1) begin
                r.first_ok = int'(sCLK_XVXENVS && xxxx_zero);
            end
            r.len++;
            if (sCLK_XVXENVS) begin
                if (int'(xxxx) != k) r.seq_ok = 0;
                k++;
                r.envs++;
            end
            if (sCLK_XVXOSC) r.osc++;
            if (xxxx_zero) r.zero++;
            if (int'(channel) != int'(xxxx[8:4]) / 8) r.ch_ok = 0;
            if (xxxx[8:4] == 5'd9) r.ch9 = int'(channel);
            if (xxxx[8:4] == 5'd31) r.ch31 = int'(channel);
            trig      = (i == trig_at);
            ovr_clr   = (i == clr_at);
            reset_reg = (i == rst_at);
            step();
            trig      = 1'b0;
            ovr_clr   = 1'b0;
            reset_reg = 1'b0;
        end
    endtask

    task automatic chk_frame(input string nm, input res_t r, input vec_t v);
        chk({nm, "_len"}, r.len, v.len);
        chk({nm, "_envs"}, r.envs, v.envs);
        chk({nm, "_osc"}, r.osc, v.osc);
        chk({nm, "_zero"}, r.zero, 1);
        chk({nm, "_done_at"}, r.done_at, v.len + 1);
        chk({nm, "_first"}, r.first_ok, 1);
        chk({nm, "_seq"}, r.seq_ok, 1);
        chk({nm, "_chan"}, r.ch_ok, 1);
        chk({nm, "_done_run"}, int'(run), 0);
        chk({nm, "_done_xxxx"}, int'(xxxx), 0);
    endtask

    initial begin
        vec_t tbl[7];
        res_t r;
        vec_t v;

        tbl[0] = '{av: 32, len: 2048, envs: 512, osc: 256};
        tbl[1] = '{av: 2,  len: 128,  envs: 32,  osc: 16};
        tbl[2] = '{av: 0,  len: 2048, envs: 512, osc: 256};
        tbl[3] = '{av: 40, len: 2048, envs: 512, osc: 256};
        tbl[4] = '{av: 1,  len: 64,   envs: 16,  osc: 8};
        tbl[5] = '{av: 33, len: 2048, envs: 512, osc: 256};
        tbl[6] = '{av: 5,  len: 320,  envs: 80,  osc: 40};

        reset_reg     = 1'b1;
        trig          = 1'b0;
        ovr_clr       = 1'b0;
        active_voices = '0;
        step();
        chk("rst_run", int'(run), 0);
        chk("rst_envs", int'(sCLK_XVXENVS), 0);
        chk("rst_osc", int'(sCLK_XVXOSC), 0);
        chk("rst_zero", int'(xxxx_zero), 0);
        chk("rst_xxxx", int'(xxxx), 0);
        chk("rst_chan", int'(channel), 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst_ovr", int'(overrun), 0);
        step();
        reset_reg = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            frame(tbl[i].av, -1, -1, -1, r);
            chk_frame($sformatf("tbl%0d", i), r, tbl[i]);
            chk($sformatf("tbl%0d_ovr", i), int'(overrun), 0);
            if (i == 0) begin
                chk("voice9_chan", r.ch9, 1);
                chk("voice31_chan", r.ch31, 3);
            end
            step();
        end

        // Late trigger mid-frame, then clear.
        frame(32, 100, -1, -1, r);
        chk("late_len", r.len, 2048);
        chk("late_done_at", r.done_at, 2049);
        chk("late_ovr", int'(overrun), 1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("clr_ovr", int'(overrun), 0);

        // Clear together with a late trigger: set wins.
        frame(1, 10, 10, -1, r);
        chk("simul_len", r.len, 64);
        chk("simul_ovr", int'(overrun), 1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("simul_clr", int'(overrun), 0);

        // Trigger on the final RUN cycle must not restart.
        frame(1, 64, -1, -1, r);
        chk("final_len", r.len, 64);
        chk("final_done_at", r.done_at, 65);
        chk("final_ovr", int'(overrun), 1);
        step();
        chk("final_no_restart", int'(run), 0);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;

        // Reset mid-frame, with overrun pending.
        frame(32, 100, -1, 500, r);
        chk("abort_len", r.len, 500);
        chk("abort_done_at", r.done_at, 0);
        chk("abort_run", int'(run), 0);
        chk("abort_xxxx", int'(xxxx), 0);
        chk("abort_done", int'(frame_done), 0);
        chk("abort_ovr", int'(overrun), 0);
        step();
        chk("abort_done_late", int'(frame_done), 0);

        v = '{av: 2, len: 128, envs: 32, osc: 16};
        frame(2, -1, -1, -1, r);
        chk_frame("clean", r, v);

        // Back-to-back: trigger issued in the frame_done cycle.
        frame(2, -1, -1, -1, r);
        chk_frame("b2b", r, v);
        chk("b2b_ovr", int'(overrun), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
